// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two master request ports and the RAM port of the
//   two-master RAM arbiter into one interface.
//
//   Signals (names follow the bus they belong to):
//     m0_*/m1_*  : req, we, addr, sel, wdata, lock (master -> arbiter)
//                  ack, rdata                      (arbiter -> master)
//     ram_*      : ce, we, addr, sel, wdata        (arbiter -> RAM)
//                  rdata                           (RAM -> arbiter)
//
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (both masters plus the RAM)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [SEL_W-1:0]  m0_sel;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_lock;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [SEL_W-1:0]  m1_sel;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [SEL_W-1:0]  ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    output m1_ack, m1_rdata,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    input  m1_ack, m1_rdata,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter and access sequencer for a single-port data RAM
//   shared by the processor data port (master 0) and a secondary
//   requester (master 1). Every access runs IDLE -> ACCESS -> RESP, so
//   one access completes every three cycles.
//
//   Ports:
//     clk_i      : clock, rising edge
//     rst_ni     : asynchronous reset, active low
//     bus        : mem_arbiter_if.slave (both masters and the RAM port)
//     m0_stall_o : processor stall request, m0_req & ~m0_ack
//
//   Optional feature:
//     MEM_ARB_LOCK_EN : when defined, a master granted with lock high
//                       keeps priority for its next request.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus,
  output logic          m0_stall_o
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              we_q;
  logic              last_q;
  logic              ramCe_q;
  logic              ramWe_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic [SEL_W-1:0]  ramSel_q;
  logic [DATA_W-1:0] ramWdata_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              grantValid_d;
  logic              grantOwner_d;

`ifdef MEM_ARB_LOCK_EN
  logic              lock_q;
  logic              hold_q;
  logic              grantLock_d;
`else
  logic              unusedLock;
  assign unusedLock = bus.m0_lock ^ bus.m1_lock;
`endif

  // Grant decision for the IDLE cycle. Contention goes to the master
  // that did not own the previous unlocked access; a locked owner that
  // asks again keeps the RAM.
  always_comb begin
    grantValid_d = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      grantOwner_d = ~last_q;
    end else begin
      grantOwner_d = bus.m1_req;
    end
`ifdef MEM_ARB_LOCK_EN
    if (hold_q && (owner_q ? bus.m1_req : bus.m0_req)) begin
      grantOwner_d = owner_q;
    end
    grantLock_d = grantOwner_d ? bus.m1_lock : bus.m0_lock;
`endif
  end

  // Access sequencer. The RAM drive registers double as the latched
  // request, so they are only non-zero during ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      ramCe_q    <= 1'b0;
      ramWe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramSel_q   <= '0;
      ramWdata_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q     <= 1'b0;
      hold_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid_d) begin
            state_q    <= ACCESS;
            owner_q    <= grantOwner_d;
            we_q       <= grantOwner_d ? bus.m1_we : bus.m0_we;
            ramCe_q    <= 1'b1;
            ramWe_q    <= grantOwner_d ? bus.m1_we : bus.m0_we;
            ramAddr_q  <= grantOwner_d ? bus.m1_addr : bus.m0_addr;
            ramSel_q   <= grantOwner_d ? bus.m1_sel : bus.m0_sel;
            ramWdata_q <= grantOwner_d ? bus.m1_wdata : bus.m0_wdata;
`ifdef MEM_ARB_LOCK_EN
            lock_q     <= grantLock_d;
            hold_q     <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          state_q    <= RESP;
          ramCe_q    <= 1'b0;
          ramWe_q    <= 1'b0;
          ramAddr_q  <= '0;
          ramSel_q   <= '0;
          ramWdata_q <= '0;
          ack0_q     <= ~owner_q;
          ack1_q     <= owner_q;
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          // The RAM data only becomes valid during RESP, so it is
          // stored here and bypassed to the master while ack is high.
          if (!we_q) begin
            if (owner_q) begin
              rdata1_q <= bus.ram_rdata;
            end else begin
              rdata0_q <= bus.ram_rdata;
            end
          end
`ifdef MEM_ARB_LOCK_EN
          if (lock_q) begin
            hold_q <= 1'b1;
          end else begin
            last_q <= owner_q;
          end
`else
          last_q <= owner_q;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_ce    = ramCe_q;
  assign bus.ram_we    = ramWe_q;
  assign bus.ram_addr  = ramAddr_q;
  assign bus.ram_sel   = ramSel_q;
  assign bus.ram_wdata = ramWdata_q;

  assign bus.m0_ack = ack0_q;
  assign bus.m1_ack = ack1_q;

  // Read data is live from the RAM in the owner's ack cycle and held
  // from the stored copy afterwards.
  assign bus.m0_rdata = (state_q == RESP && !owner_q && !we_q) ? bus.ram_rdata : rdata0_q;
  assign bus.m1_rdata = (state_q == RESP && owner_q && !we_q) ? bus.ram_rdata : rdata1_q;

  assign m0_stall_o = bus.m0_req & ~ack0_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter
//   Directed and randomized traffic for mem_arbiter, checked against a
//   transaction-level model: a word memory with byte enables, a
//   round-robin "last winner" bit with optional lock hold, and the fixed
//   three-cycle access timing.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    bit          lock;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0Stall;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .m0_stall_o (m0Stall)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered read, byte-enabled write.
  logic [31:0] ramArr [64];
  initial begin
    for (int i = 0; i < 64; i++) ramArr[i] = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_sel[b]) ramArr[bus.ram_addr[7:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
        end
      end else begin
        bus.ram_rdata <= ramArr[bus.ram_addr[7:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] refMem [64];
  logic [31:0] expRdata [2];
  bit   lastModel;
  bit   holdValid;
  bit   holdOwner;
  req_t q0[$];
  req_t q1[$];
  int   ackOrder[$];
  int   checks = 0;
  int   errors = 0;
  int   stallCycles;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts the check and reports a failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t makeReq(bit we, logic [31:0] addr, logic [3:0] sel, logic [31:0] wdata, bit lock);
    req_t r;
    r.we = we; r.addr = addr; r.sel = sel; r.wdata = wdata; r.lock = lock;
    return r;
  endfunction

  // Random request to word index 0..62; index 63 is kept for the aborted write.
  function automatic req_t randReq();
    req_t r;
    r.we        = 1'($urandom_range(0, 1));
    r.addr      = $urandom();
    r.addr[7:2] = 6'($urandom_range(0, 62));
    r.addr[1:0] = 2'b00;
    r.sel       = 4'($urandom_range(1, 15));
    r.wdata     = $urandom();
    r.lock      = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic driveHeads();
    if (q0.size() > 0) begin
      bus.m0_req = 1'b1; bus.m0_we = q0[0].we; bus.m0_addr = q0[0].addr;
      bus.m0_sel = q0[0].sel; bus.m0_wdata = q0[0].wdata; bus.m0_lock = q0[0].lock;
    end else begin
      bus.m0_req = 1'b0; bus.m0_lock = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.m1_req = 1'b1; bus.m1_we = q1[0].we; bus.m1_addr = q1[0].addr;
      bus.m1_sel = q1[0].sel; bus.m1_wdata = q1[0].wdata; bus.m1_lock = q1[0].lock;
    end else begin
      bus.m1_req = 1'b0; bus.m1_lock = 1'b0;
    end
  endtask

  task automatic resetModel();
    lastModel   = 1'b1;
    holdValid   = 1'b0;
    holdOwner   = 1'b0;
    expRdata[0] = '0;
    expRdata[1] = '0;
  endtask

  // Runs the queued requests of both masters to completion, checking
  // every cycle against the model. Starts and ends with the arbiter idle.
  task automatic applyStimulus();
    int   iter = 0;
    int   waitCnt = 0;
    int   lastAck = -1;
    bit   pend = 1'b0;
    bit   pendOwner = 1'b0;
    bit   own;
    bit   has0;
    bit   has1;
    req_t cur;
    ackOrder.delete();
    stallCycles = 0;
    @(negedge clk);
    driveHeads();
    #1;
    checkOutput("stall_start", m0Stall, bus.m0_req);
    if (m0Stall) stallCycles++;
    while (q0.size() > 0 || q1.size() > 0) begin
      @(negedge clk);
      iter++;
      waitCnt++;
      if (m0Stall) stallCycles++;
      checkOutput("stall", m0Stall, bus.m0_req & ~(pend & ~pendOwner));
      checkOutput("both_ack", bus.m0_ack & bus.m1_ack, 0);
      if (pend) begin
        if (pendOwner) cur = q1[0]; else cur = q0[0];
        checkOutput("ack0", bus.m0_ack, !pendOwner);
        checkOutput("ack1", bus.m1_ack, pendOwner);
        checkOutput("ce_in_resp", bus.ram_ce, 0);
        if (cur.we) begin
          for (int b = 0; b < 4; b++) begin
            if (cur.sel[b]) refMem[cur.addr[7:2]][8*b +: 8] = cur.wdata[8*b +: 8];
          end
        end else begin
          expRdata[pendOwner] = refMem[cur.addr[7:2]];
        end
        checkOutput("rdata0", bus.m0_rdata, expRdata[0]);
        checkOutput("rdata1", bus.m1_rdata, expRdata[1]);
        if (lastAck >= 0) checkOutput("ack_gap", iter - lastAck, 3);
        else              checkOutput("first_latency", iter, 2);
        lastAck = iter;
        ackOrder.push_back(int'(pendOwner));
`ifdef MEM_ARB_LOCK_EN
        if (cur.lock) begin
          holdValid = 1'b1;
          holdOwner = pendOwner;
        end else begin
          lastModel = pendOwner;
        end
`else
        lastModel = pendOwner;
`endif
        if (pendOwner) void'(q1.pop_front()); else void'(q0.pop_front());
        pend    = 1'b0;
        waitCnt = 0;
        driveHeads();
      end else if (bus.ram_ce === 1'b1) begin
        has0 = q0.size() > 0;
        has1 = q1.size() > 0;
        if (has0 && has1) own = !lastModel; else own = has1;
`ifdef MEM_ARB_LOCK_EN
        if (holdValid && (holdOwner ? has1 : has0)) own = holdOwner;
        holdValid = 1'b0;
`endif
        if (own) cur = q1[0]; else cur = q0[0];
        checkOutput("ram_we", bus.ram_we, cur.we);
        checkOutput("ram_addr", bus.ram_addr, cur.addr);
        checkOutput("ram_sel", bus.ram_sel, cur.sel);
        checkOutput("ram_wdata", bus.ram_wdata, cur.wdata);
        checkOutput("ack_in_access", {bus.m0_ack, bus.m1_ack}, 0);
        pend      = 1'b1;
        pendOwner = own;
      end else begin
        checkOutput("idle_ram_addr", bus.ram_addr, 0);
        checkOutput("idle_ram_wdata", bus.ram_wdata, 0);
        checkOutput("idle_ram_we_sel", {bus.ram_we, bus.ram_sel}, 0);
        if (waitCnt > 8) begin
          checks++;
          errors++;
          $error("[TB] FAIL ack_timeout waited=%0d limit=8", waitCnt);
          q0.delete();
          q1.delete();
          break;
        end
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  initial begin
    req_t r;
    int   n0;
    int   n1;
    int   expOrd4 [4];
    int   expOrd3 [3];

    for (int i = 0; i < 64; i++) refMem[i] = '0;
    resetModel();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_sel = '0;
    bus.m0_wdata = '0; bus.m0_lock = 1'b0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_sel = '0;
    bus.m1_wdata = '0; bus.m1_lock = 1'b0;

    // Reset values, with stall following m0_req combinationally.
    $display("[TB] reset state");
    @(negedge clk);
    bus.m0_req = 1'b1;
    #1;
    checkOutput("rst_stall_hi", m0Stall, 1);
    checkOutput("rst_ram_ce", bus.ram_ce, 0);
    checkOutput("rst_ram_we_sel", {bus.ram_we, bus.ram_sel}, 0);
    checkOutput("rst_ram_addr", bus.ram_addr, 0);
    checkOutput("rst_ram_wdata", bus.ram_wdata, 0);
    checkOutput("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
    checkOutput("rst_rdata0", bus.m0_rdata, 0);
    checkOutput("rst_rdata1", bus.m1_rdata, 0);
    bus.m0_req = 1'b0;
    #1;
    checkOutput("rst_stall_lo", m0Stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write access aborts it without an ack.
    $display("[TB] reset mid-access");
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0000_00FC;
    bus.m0_sel = 4'hF; bus.m0_wdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("abort_ce_before", bus.ram_ce, 1);
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    #1;
    checkOutput("abort_ce_now", bus.ram_ce, 0);
    checkOutput("abort_we_now", bus.ram_we, 0);
    resetModel();
    @(negedge clk);
    checkOutput("abort_no_ack_rst", {bus.m0_ack, bus.m1_ack}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_ack", {bus.m0_ack, bus.m1_ack}, 0);
    checkOutput("abort_idle_ce", bus.ram_ce, 0);
    r = randReq(); r.we = 1'b0;
    q0.push_back(r);
    applyStimulus();

    // m0 write then read back at 0x10.
    $display("[TB] m0 write/read 0x10");
    q0.push_back(makeReq(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0));
    q0.push_back(makeReq(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0));
    applyStimulus();
    checkOutput("m0_readback", bus.m0_rdata, 32'hDEAD_BEEF);
    checkOutput("m0_stall_cycles", stallCycles, 4);

    // m1 partial write: sel only during ACCESS, m1_rdata untouched.
    $display("[TB] m1 partial write 0x20");
    q1.push_back(makeReq(1'b1, 32'h20, 4'b0011, $urandom(), 1'b0));
    applyStimulus();
    checkOutput("m1_rdata_kept", bus.m1_rdata, expRdata[1]);

    // Sustained contention alternates starting from m0 (last=m1 here).
    $display("[TB] contention");
    for (int i = 0; i < 2; i++) begin
      r = randReq(); r.we = 1'b0; r.lock = 1'b0; q0.push_back(r);
      r = randReq(); r.we = 1'b0; r.lock = 1'b0; q1.push_back(r);
    end
    applyStimulus();
    expOrd4 = '{0, 1, 0, 1};
    checkOutput("contention_count", ackOrder.size(), 4);
    for (int i = 0; i < 4 && i < ackOrder.size(); i++) checkOutput("contention_order", ackOrder[i], expOrd4[i]);

    // Lock: m1 locked while m0 waits.
    $display("[TB] lock sequence");
    r = randReq(); r.lock = 1'b0; q0.push_back(r);
    applyStimulus();
    r = randReq(); r.lock = 1'b1; q1.push_back(r);
    r = randReq(); r.lock = 1'b0; q1.push_back(r);
    r = randReq(); r.lock = 1'b0; q0.push_back(r);
    applyStimulus();
`ifdef MEM_ARB_LOCK_EN
    expOrd3 = '{1, 1, 0};
`else
    expOrd3 = '{1, 0, 1};
`endif
    checkOutput("lock_count", ackOrder.size(), 3);
    for (int i = 0; i < 3 && i < ackOrder.size(); i++) checkOutput("lock_order", ackOrder[i], expOrd3[i]);

    // Randomized mixed traffic.
    $display("[TB] random traffic");
    for (int round = 0; round < 3; round++) begin
      n0 = $urandom_range(round == 2 ? 0 : 4, 10);
      n1 = $urandom_range(4, 10);
      for (int i = 0; i < n0; i++) q0.push_back(randReq());
      for (int i = 0; i < n1; i++) q1.push_back(randReq());
      applyStimulus();
      checkOutput("random_count", ackOrder.size(), n0 + n1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
